product_accumulator: RTL
========================

// Module: product_accumulator
// PURPOSE
// - Downstream stage of the 2x2 array multiplier: consumes its 4-bit products and sums a
//   fixed-length frame of COUNT products into one accumulated result.
// - Valid/ready handshake on both sides. Each frame result is held until the consumer accepts it.
// - Used to build dot products from the combinational multiplier without widening that multiplier.
// PARAMETERS
// - PW     4  product (input) width; matches the multiplier output p[3:0]
// - AW     6  accumulator/result width; default holds 4*9=36 without overflow
// - COUNT  4  products per frame; legal range 1..2**CW
// - CW     2  frame counter width
// PORTS
// - clk        input   1   single clock, rising edge
// - rst        input   1   asynchronous, active-high reset
// - clr        input   1   synchronous frame abort; clears acc/cnt/ovf
// - p          input   PW  product from multiplier
// - p_valid    input   1   p is valid this cycle
// - p_ready    output  1   block accepts p this cycle
// - sum        output  AW  accumulated frame result
// - sum_valid  output  1   sum holds a completed frame
// - sum_ready  input   1   consumer accepts sum
// - cnt        output  CW  products accepted in the current frame
// - ovf        output  1   frame accumulation exceeded 2**AW-1 (sticky per frame)
// BEHAVIOUR
// - Reset (async, rst=1): state=ACC, acc=0, sum=0, cnt=0, ovf=0, sum_valid=0, p_ready=1 from reset release.
// - Two states: ACC and HOLD.
// - ACC:
//   - p_ready=1, sum_valid=0.
//   - Accept when p_valid&&p_ready: acc<=acc+p (zero-extended to AW), cnt<=cnt+1.
//   - Accepting the product with cnt==COUNT-1 completes the frame: sum<=acc+p, acc<=0, cnt<=0,
//     state<=HOLD.
//   - sum_valid rises the cycle after the last accept (latency 1).
// - HOLD:
//   - p_ready=0, sum_valid=1. sum, ovf and cnt stay stable under backpressure.
//   - When sum_ready=1: sum_valid falls next cycle, ovf<=0, state<=ACC. sum keeps its last value.
//   - p_valid in HOLD is ignored; no product is lost because p_ready=0.
// - Gaps: p_valid low in ACC leaves acc and cnt unchanged. No timeout.
// - Overflow: computed on the AW+1-bit sum acc+p.
//   - ovf sets on carry-out and stays set until the frame result is accepted, clr, or rst.
//   - Default: acc wraps modulo 2**AW.
// - clr=1 (sync): acc=0, cnt=0, ovf=0, sum_valid=0, state<=ACC; a frame in HOLD is discarded.
//   - clr has priority over a simultaneous accept. rst has priority over everything.
// - Reset mid-frame: partial sum is dropped; the next frame starts from acc=0, cnt=0.
// - COUNT==1: every accepted product goes straight to HOLD with sum=p.
// CONFIGURATION
// - PRODUCT_ACC_SAT_EN defined:
//   - On carry-out, acc/sum clamp to 2**AW-1 and stay there for the rest of the frame.
//   - ovf behaves as in the default build.
// - PRODUCT_ACC_SAT_EN undefined: wrap-around as above. No other behaviour differs.
// TESTING
// - Frame of products 9,9,9,9 with p_valid held high, sum_ready=1 -> sum=36 and sum_valid=1
//   one cycle after the 4th accept, ovf=0, cnt back to 0.
// - Products 1,2,3,4 with p_valid gaps of 2 cycles between them -> sum=10; cnt steps 1,2,3 then 0;
//   p_ready stays 1 during the gaps.
// - sum_ready=0 for 5 cycles after frame 6,6,6,6 -> sum=24 stable, p_ready=0, p_valid pulses ignored;
//   sum_ready=1 -> sum_valid=0 next cycle and the next frame sums correctly.
// - AW=5 with frame 9,9,9,9 -> default build: sum=4, ovf=1; PRODUCT_ACC_SAT_EN build: sum=31, ovf=1.
// - rst pulse mid-cycle after 2 accepts (9,4) -> all outputs 0 immediately; next frame 1,1,1,1 gives sum=4.
// - clr asserted in HOLD and in the same cycle as an accept -> sum_valid=0, cnt=0, acc=0, product dropped.

Source files
------------

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Purpose:
//   Downstream stage of the 2x2 array multiplier. Accepts a stream of PW-bit
//   products over a valid/ready handshake and sums a fixed-length frame of
//   COUNT products into one AW-bit result. The finished result is held on the
//   output handshake until the consumer takes it; no product is accepted while
//   a result is pending.
//
// Build option:
//   PRODUCT_ACC_SAT_EN  when defined, the accumulator clamps to 2**AW-1 on a
//                       carry-out and stays there for the rest of the frame.
//                       When undefined, the accumulator wraps modulo 2**AW.
//                       The ovf flag behaves identically in both builds.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds its data stable while valid=1 and ready=0. Ready never
//   depends combinationally on valid; here p_ready and sum_valid are pure
//   functions of the registered state.
//
// Ports:
//   clk          in   1    single clock, rising edge
//   rst          in   1    asynchronous active-high reset
//   clr          in   1    synchronous frame abort (clears acc/cnt/ovf, drops HOLD)
//   p            in   PW   product from the multiplier
//   p_valid      in   1    p is valid this cycle
//   p_ready      out  1    block accepts p this cycle (ACC state)
//   sum          out  AW   last completed frame result
//   sum_valid    out  1    sum holds a completed frame not yet accepted
//   sum_ready    in   1    consumer accepts sum
//   cnt          out  CW   products accepted in the current frame
//   ovf          out  1    current frame overflowed 2**AW-1 (sticky per frame)
//   dbg_state_o  out  1    FSM state for observation (0=ACC, 1=HOLD)
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int PW    = 4,
    parameter int AW    = 6,
    parameter int COUNT = 4,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [PW-1:0] p,
    input  logic          p_valid,
    output logic          p_ready,
    output logic [AW-1:0] sum,
    output logic          sum_valid,
    input  logic          sum_ready,
    output logic [CW-1:0] cnt,
    output logic          ovf,
    output logic          dbg_state_o
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q,   acc_d;
    logic [AW-1:0] sum_q,   sum_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          ovf_q,   ovf_d;

    // One extra bit on the adder so the carry-out is visible as overflow.
    logic [AW:0]   add_full;
    logic          add_carry;
    logic [AW-1:0] add_res;
    logic          last_beat;

    assign add_full  = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, p};
    assign add_carry = add_full[AW];

`ifdef PRODUCT_ACC_SAT_EN
    // Once clamped, acc sits at all-ones; any further nonzero product carries
    // again and re-clamps, a zero product leaves it unchanged, so the value
    // stays pinned for the rest of the frame without extra state.
    assign add_res = add_carry ? {AW{1'b1}} : add_full[AW-1:0];
`else
    assign add_res = add_full[AW-1:0];
`endif

    // The product that arrives while cnt == COUNT-1 closes the frame.
    assign last_beat = (cnt_q == CW'(COUNT - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clr) begin
            // Abort wins over any accept in the same cycle. sum keeps the last
            // delivered value; only its valid flag is dropped via the state.
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (p_valid) begin
                        ovf_d = ovf_q | add_carry;
                        if (last_beat) begin
                            sum_d   = add_res;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            acc_d = add_res;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // ovf belongs to the held frame and is released with it.
                    if (sum_ready) begin
                        ovf_d   = 1'b0;
                        state_d = ST_ACC;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign p_ready     = (state_q == ST_ACC);
    assign sum_valid   = (state_q == ST_HOLD);
    assign sum         = sum_q;
    assign cnt         = cnt_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule
